// File: rtl/cmerge2_cache_sync_if.sv
// cmerge2_cache_sync_if: the branch-side and downstream-side 2-phase handshake
// bundle for the two-way cache merge. master = environment, slave = merge.
interface cmerge2_cache_sync_if #(
  parameter int DATA_W = 8
);
  logic              i_drive0;
  logic              i_drive1;
  logic [DATA_W-1:0] i_data0;
  logic [DATA_W-1:0] i_data1;
  logic              o_free0;
  logic              o_free1;
  logic              o_driveNext;
  logic              o_sel;
  logic [DATA_W-1:0] o_data;
  logic              i_freeNext;
  logic              o_fire;

  modport master (
    output i_drive0, i_drive1, i_data0, i_data1, i_freeNext,
    input  o_free0, o_free1, o_driveNext, o_sel, o_data, o_fire
  );

  modport slave (
    input  i_drive0, i_drive1, i_data0, i_data1, i_freeNext,
    output o_free0, o_free1, o_driveNext, o_sel, o_data, o_fire
  );
endinterface

// File: rtl/cmerge2_cache_sync.sv
// cmerge2_cache_sync: two-way 2-phase merge re-joining the cache controller's
// conditional fork. Branch requests and the downstream acknowledge are
// synchronised into clk; one winner at a time is forwarded downstream and its
// free phase is toggled once downstream acknowledges.
// Optional macro CMERGE2_FIXED_PRIO_EN: branch 0 always wins a tie (no
// round-robin pointer). Default build uses round-robin arbitration.
module cmerge2_cache_sync #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  cmerge2_cache_sync_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] drv0_sync_q;
  logic [SYNC_STAGES-1:0] drv1_sync_q;
  logic [SYNC_STAGES-1:0] free_sync_q;
  logic                   drv0_s;
  logic                   drv1_s;
  logic                   free_s;

  logic              drive_next_q, drive_next_d;
  logic              free0_q, free0_d;
  logic              free1_q, free1_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fire_q, fire_d;
`ifdef CMERGE2_FIXED_PRIO_EN
`else
  logic              last_q, last_d;
`endif

  logic pend0;
  logic pend1;
  logic winner;

  assign drv0_s = drv0_sync_q[SYNC_STAGES-1];
  assign drv1_s = drv1_sync_q[SYNC_STAGES-1];
  assign free_s = free_sync_q[SYNC_STAGES-1];

  // A branch is pending while its request phase differs from its free phase.
  assign pend0 = drv0_s ^ free0_q;
  assign pend1 = drv1_s ^ free1_q;

`ifdef CMERGE2_FIXED_PRIO_EN
  assign winner = pend0 ? 1'b0 : 1'b1;
`else
  assign winner = (pend0 && pend1) ? ~last_q : pend1;
`endif

  // Synchronise the asynchronous phase inputs into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv0_sync_q <= '0;
      drv1_sync_q <= '0;
      free_sync_q <= '0;
    end else begin
      drv0_sync_q <= {drv0_sync_q[SYNC_STAGES-2:0], bus.i_drive0};
      drv1_sync_q <= {drv1_sync_q[SYNC_STAGES-2:0], bus.i_drive1};
      free_sync_q <= {free_sync_q[SYNC_STAGES-2:0], bus.i_freeNext};
    end
  end

  // Next-state and output decode: grant in IDLE, wait for downstream in BUSY.
  always_comb begin
    state_d      = state_q;
    drive_next_d = drive_next_q;
    free0_d      = free0_q;
    free1_d      = free1_q;
    sel_d        = sel_q;
    data_d       = data_q;
    fire_d       = 1'b0;
`ifdef CMERGE2_FIXED_PRIO_EN
`else
    last_d       = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (pend0 || pend1) begin
          sel_d        = winner;
          data_d       = winner ? bus.i_data1 : bus.i_data0;
          drive_next_d = ~drive_next_q;
          fire_d       = 1'b1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        // Downstream has acknowledged once its phase catches up with ours.
        if (free_s == drive_next_q) begin
          if (sel_q) free1_d = ~free1_q;
          else       free0_d = ~free0_q;
`ifdef CMERGE2_FIXED_PRIO_EN
`else
          last_d = sel_q;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; o_free toggle and return to IDLE share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      drive_next_q <= 1'b0;
      free0_q      <= 1'b0;
      free1_q      <= 1'b0;
      sel_q        <= 1'b0;
      data_q       <= '0;
      fire_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      drive_next_q <= drive_next_d;
      free0_q      <= free0_d;
      free1_q      <= free1_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      fire_q       <= fire_d;
    end
  end

`ifdef CMERGE2_FIXED_PRIO_EN
`else
  // Round-robin pointer: starts at 1 so branch 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  assign bus.o_driveNext = drive_next_q;
  assign bus.o_free0     = free0_q;
  assign bus.o_free1     = free1_q;
  assign bus.o_sel       = sel_q;
  assign bus.o_data      = data_q;
  assign bus.o_fire      = fire_q;

endmodule

// File: tb/tb_cmerge2_cache_sync.sv
// tb_cmerge2_cache_sync: directed bench with grant/free scoreboard queues and
// a negedge monitor process for the two-way 2-phase merge.
module tb_cmerge2_cache_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cmerge2_cache_sync_if #(.DATA_W(8)) bus ();

  cmerge2_cache_sync #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] grant_q[$];   // {sel, data}
  int         free_q[$];    // branch index

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s at %0t", name, what, $time);
  endtask

  // Monitor: pop and compare on every grant pulse and every free toggle.
  initial begin
    logic prev_dn, prev_f0, prev_f1, exp_dn;
    logic [8:0] g;
    int b;
    prev_dn = 1'b0; prev_f0 = 1'b0; prev_f1 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.o_fire) begin
          if (grant_q.size() == 0) fail_msg("grant_unexpected", "grant with empty queue");
          else begin
            g = grant_q.pop_front();
            exp_dn = ~prev_dn;
            check("grant_sel", {31'd0, bus.o_sel}, {31'd0, g[8]});
            check("grant_data", {24'd0, bus.o_data}, {24'd0, g[7:0]});
            check("grant_toggle", {31'd0, bus.o_driveNext}, {31'd0, exp_dn});
          end
        end
        if (bus.o_free0 != prev_f0 || bus.o_free1 != prev_f1) begin
          b = (bus.o_free1 != prev_f1) ? 1 : 0;
          if (free_q.size() == 0) fail_msg("free_unexpected", "free toggle with empty queue");
          else check("free_branch", b, free_q.pop_front());
        end
      end
      prev_dn = bus.o_driveNext;
      prev_f0 = bus.o_free0;
      prev_f1 = bus.o_free1;
    end
  end

  task automatic req(input int k, input logic [7:0] d);
    @(negedge clk);
    if (k == 0) begin bus.i_data0 = d; bus.i_drive0 = ~bus.i_drive0; end
    else        begin bus.i_data1 = d; bus.i_drive1 = ~bus.i_drive1; end
  endtask

  task automatic req_both(input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clk);
    bus.i_data0 = d0; bus.i_drive0 = ~bus.i_drive0;
    bus.i_data1 = d1; bus.i_drive1 = ~bus.i_drive1;
  endtask

  task automatic expect_grant(input logic s, input logic [7:0] d);
    grant_q.push_back({s, d});
  endtask

  // Count rising edges until o_fire; exp_lat 0 skips the latency comparison.
  task automatic wait_fire(input string name, input int exp_lat);
    int cnt;
    bit seen;
    cnt = 0; seen = 0;
    while (!seen && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (bus.o_fire) seen = 1;
    end
    if (!seen) fail_msg(name, "no grant within 200 cycles");
    else if (exp_lat > 0) check(name, cnt, exp_lat);
  endtask

  // Toggle i_freeNext, expect a free on branch k three edges later.
  task automatic ack(input int k, input string name);
    logic old;
    int cnt;
    bit seen;
    @(negedge clk);
    old = (k == 1) ? bus.o_free1 : bus.o_free0;
    free_q.push_back(k);
    bus.i_freeNext = ~bus.i_freeNext;
    cnt = 0; seen = 0;
    while (!seen && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (((k == 1) ? bus.o_free1 : bus.o_free0) != old) seen = 1;
    end
    if (!seen) fail_msg(name, "no free toggle within 200 cycles");
    else check(name, cnt, 3);
  endtask

  task automatic reset_apply(input string name);
    rst_n = 1'b0;
    bus.i_drive0 = 1'b0; bus.i_drive1 = 1'b0; bus.i_freeNext = 1'b0;
    bus.i_data0 = '0; bus.i_data1 = '0;
    #1;
    check({name, "_free0"}, {31'd0, bus.o_free0}, 0);
    check({name, "_free1"}, {31'd0, bus.o_free1}, 0);
    check({name, "_drive_next"}, {31'd0, bus.o_driveNext}, 0);
    check({name, "_sel"}, {31'd0, bus.o_sel}, 0);
    check({name, "_fire"}, {31'd0, bus.o_fire}, 0);
    check({name, "_data"}, {24'd0, bus.o_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       dn_hold;
    logic [7:0] data_hold;
    int         changes;
    logic       exp_f1;

    bus.i_drive0 = 1'b0; bus.i_drive1 = 1'b0; bus.i_freeNext = 1'b0;
    bus.i_data0 = '0; bus.i_data1 = '0;
    @(negedge clk);
    reset_apply("reset");

    // Single request on branch 0.
    req(0, 8'hA5); expect_grant(1'b0, 8'hA5);
    wait_fire("single_req_lat", 3);
    check("single_drive_next", {31'd0, bus.o_driveNext}, 1);
    ack(0, "single_ack_lat");
    check("single_free0", {31'd0, bus.o_free0}, 1);
    check("single_free1", {31'd0, bus.o_free1}, 0);

    // Tie straight after reset: branch 0 first, then branch 1 one cycle after ack.
    @(negedge clk);
    reset_apply("reset2");
    req_both(8'h11, 8'h22);
    expect_grant(1'b0, 8'h11); expect_grant(1'b1, 8'h22);
    wait_fire("tie1_first_lat", 3);
    ack(0, "tie1_ack0_lat");
    wait_fire("tie1_second_lat", 1);
    ack(1, "tie1_ack1_lat");

    // Repeat tie: last grant was branch 1, so branch 0 wins again.
    req_both(8'h33, 8'h44);
    expect_grant(1'b0, 8'h33); expect_grant(1'b1, 8'h44);
    wait_fire("tie2_first", 0);
    ack(0, "tie2_ack0_lat");
    wait_fire("tie2_second_lat", 1);
    ack(1, "tie2_ack1_lat");

    // Branch 0 alone, then a tie: round-robin favours 1, fixed priority favours 0.
    req(0, 8'h55); expect_grant(1'b0, 8'h55);
    wait_fire("solo0", 0);
    ack(0, "solo0_ack_lat");
    req_both(8'h66, 8'h77);
`ifdef CMERGE2_FIXED_PRIO_EN
    expect_grant(1'b0, 8'h66); expect_grant(1'b1, 8'h77);
    wait_fire("tie3_first", 0);
    ack(0, "tie3_ack_a_lat");
    wait_fire("tie3_second_lat", 1);
    ack(1, "tie3_ack_b_lat");
`else
    expect_grant(1'b1, 8'h77); expect_grant(1'b0, 8'h66);
    wait_fire("tie3_first", 0);
    ack(1, "tie3_ack_a_lat");
    wait_fire("tie3_second_lat", 1);
    ack(0, "tie3_ack_b_lat");
`endif

    // Stall: downstream withholds acknowledge for 50 cycles while branch 1 requests.
    req(0, 8'h5A); expect_grant(1'b0, 8'h5A);
    wait_fire("stall_grant_lat", 3);
    dn_hold = bus.o_driveNext;
    data_hold = bus.o_data;
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 10) begin
        bus.i_data1 = 8'hC3; bus.i_drive1 = ~bus.i_drive1;
        expect_grant(1'b1, 8'hC3);
      end
      if (bus.o_driveNext != dn_hold || bus.o_data != data_hold) changes++;
    end
    check("stall_output_changes", changes, 0);
    ack(0, "stall_ack0_lat");
    wait_fire("stall_next_lat", 1);
    ack(1, "stall_ack1_lat");

    // Reset while BUSY: outputs clear asynchronously, then a fresh grant works.
    req(0, 8'h99); expect_grant(1'b0, 8'h99);
    wait_fire("busy_grant_lat", 3);
    @(negedge clk); #2;
    reset_apply("reset_busy");
    req(0, 8'h3E); expect_grant(1'b0, 8'h3E);
    wait_fire("post_reset_lat", 3);
    ack(0, "post_reset_ack_lat");

    // Phase wrap: four full transactions on branch 1.
    for (int i = 0; i < 4; i++) begin
      req(1, 8'(8'h80 + i)); expect_grant(1'b1, 8'(8'h80 + i));
      wait_fire("wrap_grant_lat", 3);
      ack(1, "wrap_ack_lat");
      exp_f1 = (i % 2 == 0) ? 1'b1 : 1'b0;
      check("wrap_free1_phase", {31'd0, bus.o_free1}, {31'd0, exp_f1});
      check("wrap_dn_matches_ack", {31'd0, bus.o_driveNext}, {31'd0, bus.i_freeNext});
    end

    repeat (5) @(negedge clk);
    check("grant_queue_drained", grant_q.size(), 0);
    check("free_queue_drained", free_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
